if_fetch_unit: RTL and testbench

- Instruction fetch front end. It owns the PC register and drives the synchronous instruction memory.
- It delivers a PC-aligned {valid, pc, instr, pred_taken} bundle to the IF/ID stage. This is the producing end of the IF→IF/ID interface.
- It keeps the PC and instruction in step across the one-cycle memory latency. It absorbs stalls with a hold buffer and kills wrong-path fetches on redirect.
- It applies gshare predictions as they arrive.

---
 rtl/if_pkg.sv | 22 ++
 rtl/if_fetch_unit_if.sv | 41 ++++
 rtl/if_hold_buffer.sv | 33 +++
 rtl/if_fetch_unit.sv | 93 +++++++++
 tb/tb_if_fetch_unit.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/if_pkg.sv
// Shared word type, constants, output bundle and PC alignment helper for the
// instruction fetch front end.
package if_pkg;

  typedef logic [31:0] word_t;

  localparam word_t IF_NOP_INSTR = 32'h0000_0013;
  localparam word_t IF_RESET_PC  = 32'h0000_0000;

  typedef struct packed {
    logic  valid;
    word_t pc;
    word_t instr;
    logic  pred_taken;
  } fetch_bundle_t;

  // Fetch addresses are always word aligned; low two bits of any target are dropped.
  function automatic word_t align_pc(input word_t addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory and IF -> IF/ID signals of the fetch unit.
// IF_PERF_CNT_EN adds the fetch/bubble counter outputs.
interface if_fetch_unit_if;
  import if_pkg::*;

  logic  i_stall;
  logic  i_redirect_valid;
  word_t i_redirect_pc;
  logic  i_pred_taken;
  word_t i_pred_target;
  logic  o_imem_req;
  word_t o_imem_addr;
  word_t i_imem_rdata;
  logic  o_valid;
  word_t o_pc;
  word_t o_instr;
  logic  o_pred_taken;
`ifdef IF_PERF_CNT_EN
  word_t o_fetch_cnt;
  word_t o_bubble_cnt;
`endif

  modport master (
    input  i_stall, i_redirect_valid, i_redirect_pc, i_pred_taken, i_pred_target,
    input  i_imem_rdata,
    output o_imem_req, o_imem_addr, o_valid, o_pc, o_instr, o_pred_taken
`ifdef IF_PERF_CNT_EN
    , output o_fetch_cnt, o_bubble_cnt
`endif
  );

  modport slave (
    output i_stall, i_redirect_valid, i_redirect_pc, i_pred_taken, i_pred_target,
    output i_imem_rdata,
    input  o_imem_req, o_imem_addr, o_valid, o_pc, o_instr, o_pred_taken
`ifdef IF_PERF_CNT_EN
    , input o_fetch_cnt, o_bubble_cnt
`endif
  );

endinterface

// File: rtl/if_hold_buffer.sv
// Stall buffer: captures the returning instruction on the first stall cycle and
// keeps presenting it until the stall releases; a redirect discards it.
module if_hold_buffer
  import if_pkg::*;
(
  input  logic  i_clk,
  input  logic  i_reset,
  input  logic  i_stall,
  input  logic  i_redirect,
  input  logic  i_f1_valid,
  input  word_t i_rdata,
  output logic  o_hold_valid,
  output word_t o_hold_instr
);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_hold_valid <= 1'b0;
      o_hold_instr <= IF_NOP_INSTR;
    end else if (i_redirect) begin
      o_hold_valid <= 1'b0;
    end else if (i_stall) begin
      // memory data is only valid the cycle after a request, so grab it once
      if (!o_hold_valid && i_f1_valid) begin
        o_hold_valid <= 1'b1;
        o_hold_instr <= i_rdata;
      end
    end else begin
      o_hold_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch front end: owns the PC, drives the synchronous imem and
// hands {valid, pc, instr, pred_taken} to IF/ID. IF_PERF_CNT_EN adds counters.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter word_t RESET_PC  = IF_RESET_PC,
  parameter word_t NOP_INSTR = IF_NOP_INSTR
) (
  input logic           i_clk,
  input logic           i_reset,
  if_fetch_unit_if.master fe
);

  word_t         pc_q;
  word_t         pc_next;
  logic          f1_valid;
  word_t         f1_pc;
  logic          f1_pred;
  logic          hold_valid;
  word_t         hold_instr;
  fetch_bundle_t bundle;

  always_comb begin
    if (fe.i_redirect_valid)  pc_next = align_pc(fe.i_redirect_pc);
    else if (fe.i_stall)      pc_next = pc_q;
    else if (fe.i_pred_taken) pc_next = align_pc(fe.i_pred_target);
    else                      pc_next = pc_q + 32'd4;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pc_q     <= RESET_PC;
      f1_valid <= 1'b0;
      f1_pc    <= RESET_PC;
      f1_pred  <= 1'b0;
    end else begin
      pc_q <= pc_next;
      if (fe.i_redirect_valid) begin
        f1_valid <= 1'b0;
      end else if (!fe.i_stall) begin
        f1_valid <= 1'b1;
        f1_pc    <= pc_q;
        f1_pred  <= fe.i_pred_taken;
      end
    end
  end

  if_hold_buffer u_hold (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_stall      (fe.i_stall),
    .i_redirect   (fe.i_redirect_valid),
    .i_f1_valid   (f1_valid),
    .i_rdata      (fe.i_imem_rdata),
    .o_hold_valid (hold_valid),
    .o_hold_instr (hold_instr)
  );

  // A redirect kills the in-flight fetch in the same cycle it is resolved.
  always_comb begin
    bundle.valid      = f1_valid && !fe.i_redirect_valid;
    bundle.pc         = f1_pc;
    bundle.pred_taken = f1_pred;
    bundle.instr      = !bundle.valid ? NOP_INSTR
                        : (hold_valid ? hold_instr : fe.i_imem_rdata);
  end

  assign fe.o_imem_req   = !i_reset && (!fe.i_stall || fe.i_redirect_valid);
  assign fe.o_imem_addr  = pc_q;
  assign fe.o_valid      = bundle.valid;
  assign fe.o_pc         = bundle.pc;
  assign fe.o_instr      = bundle.instr;
  assign fe.o_pred_taken = bundle.pred_taken;

`ifdef IF_PERF_CNT_EN
  word_t fetch_cnt_q;
  word_t bubble_cnt_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (bundle.valid && !fe.i_stall) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (!bundle.valid) bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign fe.o_fetch_cnt  = fetch_cnt_q;
  assign fe.o_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus randomized
// stall/redirect/prediction traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_if_fetch_unit;
  import if_pkg::*;

  logic clk;
  logic rst;
  if_fetch_unit_if fe();

  if_fetch_unit dut (.i_clk(clk), .i_reset(rst), .fe(fe));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;

  // model: next fetch address and the instruction currently offered to IF/ID
  logic [31:0] m_pc, m_fpc;
  logic        m_valid, m_pred;
  logic [31:0] m_fetch_cnt, m_bubble_cnt;
  logic        mem_pend;
  logic [31:0] mem_addr;
  // expectations for the cycle being applied
  logic        e_req, e_valid, e_pred, c_stall;
  logic [31:0] e_addr, e_pc, e_instr;

  // program image: every address holds a distinct word derived from it
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[31:16] ^ 16'h0F0F};
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_fpc = 32'h0; m_valid = 1'b0; m_pred = 1'b0;
    m_fetch_cnt = 32'h0; m_bubble_cnt = 32'h0; mem_pend = 1'b0;
  endtask

  // called at a negedge: drive inputs and form the expected outputs
  task automatic apply(input logic s, input logic r, input logic [31:0] rpc,
                       input logic pt, input logic [31:0] ptgt);
    fe.i_stall = s; fe.i_redirect_valid = r; fe.i_redirect_pc = rpc;
    fe.i_pred_taken = pt; fe.i_pred_target = ptgt;
    #1;
    c_stall = s;
    e_req   = !s || r;
    e_addr  = m_pc;
    e_valid = m_valid && !r;
    e_pc    = m_fpc;
    e_pred  = m_pred;
    e_instr = e_valid ? mem_word(m_fpc) : IF_NOP_INSTR;
  endtask

  // advance one clock: memory model, model state update, back to next negedge
  task automatic advance();
    mem_pend = fe.o_imem_req;
    mem_addr = fe.o_imem_addr;
    if (e_valid && !c_stall) m_fetch_cnt = m_fetch_cnt + 32'd1;
    if (!e_valid) m_bubble_cnt = m_bubble_cnt + 32'd1;
    if (fe.i_redirect_valid) begin
      m_pc = {fe.i_redirect_pc[31:2], 2'b00};
      m_valid = 1'b0;
    end else if (!fe.i_stall) begin
      m_valid = 1'b1;
      m_fpc   = m_pc;
      m_pred  = fe.i_pred_taken;
      m_pc    = fe.i_pred_taken ? {fe.i_pred_target[31:2], 2'b00} : m_pc + 32'd4;
    end
    @(posedge clk);
    #1;
    fe.i_imem_rdata = mem_pend ? mem_word(mem_addr) : $urandom;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fe.i_stall = 1'b0; fe.i_redirect_valid = 1'b0; fe.i_redirect_pc = '0;
    fe.i_pred_taken = 1'b0; fe.i_pred_target = '0; fe.i_imem_rdata = $urandom;
    model_reset();
    repeat (2) @(negedge clk);
    n_vec++; if (fe.o_imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req got %0b want 0", fe.o_imem_req); end
    n_vec++; if (fe.o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", fe.o_valid); end
    n_vec++; if (fe.o_instr !== IF_NOP_INSTR) begin n_err++; $display("FAIL reset_instr got %h want %h", fe.o_instr, IF_NOP_INSTR); end
    n_vec++; if (fe.o_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h want 0", fe.o_pc); end
    n_vec++; if (fe.o_pred_taken !== 1'b0) begin n_err++; $display("FAIL reset_pred got %0b want 0", fe.o_pred_taken); end
`ifdef IF_PERF_CNT_EN
    n_vec++; if (fe.o_fetch_cnt !== 32'h0 || fe.o_bubble_cnt !== 32'h0) begin n_err++; $display("FAIL reset_cnt got %h/%h want 0/0", fe.o_fetch_cnt, fe.o_bubble_cnt); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    logic [31:0] p;
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      p = 32'((i - 1) * 4);
      n_vec++; if (fe.o_imem_req !== 1'b1 || fe.o_imem_addr !== 32'(i * 4)) begin n_err++; $display("FAIL seq_req cyc%0d got %0b/%h want 1/%h", i, fe.o_imem_req, fe.o_imem_addr, 32'(i * 4)); end
      n_vec++; if (fe.o_valid !== (i > 0)) begin n_err++; $display("FAIL seq_valid cyc%0d got %0b want %0b", i, fe.o_valid, i > 0); end
      if (i > 0) begin
        n_vec++; if (fe.o_pc !== p || fe.o_instr !== mem_word(p)) begin n_err++; $display("FAIL seq_data cyc%0d got %h/%h want %h/%h", i, fe.o_pc, fe.o_instr, p, mem_word(p)); end
      end
      advance();
    end
  endtask

  task automatic test_stall();
    for (int k = 0; k < 3; k++) begin
      apply(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      n_vec++; if (fe.o_imem_req !== 1'b0) begin n_err++; $display("FAIL stall_req cyc%0d got %0b want 0", k, fe.o_imem_req); end
      n_vec++; if (fe.o_valid !== 1'b1 || fe.o_pc !== 32'h8 || fe.o_instr !== mem_word(32'h8)) begin n_err++; $display("FAIL stall_hold cyc%0d got %0b/%h/%h want 1/8/%h", k, fe.o_valid, fe.o_pc, fe.o_instr, mem_word(32'h8)); end
      advance();
    end
    apply(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    n_vec++; if (fe.o_valid !== 1'b1 || fe.o_pc !== 32'h8 || fe.o_instr !== mem_word(32'h8)) begin n_err++; $display("FAIL stall_release got %0b/%h/%h want 1/8/%h", fe.o_valid, fe.o_pc, fe.o_instr, mem_word(32'h8)); end
    n_vec++; if (fe.o_imem_req !== 1'b1 || fe.o_imem_addr !== 32'hC) begin n_err++; $display("FAIL stall_resume_req got %0b/%h want 1/c", fe.o_imem_req, fe.o_imem_addr); end
    advance();
    apply(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    n_vec++; if (fe.o_valid !== 1'b1 || fe.o_pc !== 32'hC || fe.o_instr !== mem_word(32'hC)) begin n_err++; $display("FAIL stall_next got %0b/%h/%h want 1/c/%h", fe.o_valid, fe.o_pc, fe.o_instr, mem_word(32'hC)); end
    advance();
  endtask

  task automatic test_redirect();
    apply(1'b0, 1'b1, 32'h100, 1'b0, 32'h0);
    n_vec++; if (fe.o_valid !== 1'b0 || fe.o_instr !== IF_NOP_INSTR) begin n_err++; $display("FAIL redir_t got %0b/%h want 0/nop", fe.o_valid, fe.o_instr); end
    advance();
    apply(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    n_vec++; if (fe.o_valid !== 1'b0) begin n_err++; $display("FAIL redir_t1_valid got %0b want 0", fe.o_valid); end
    n_vec++; if (fe.o_imem_req !== 1'b1 || fe.o_imem_addr !== 32'h100) begin n_err++; $display("FAIL redir_t1_req got %0b/%h want 1/100", fe.o_imem_req, fe.o_imem_addr); end
    advance();
    apply(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    n_vec++; if (fe.o_valid !== 1'b1 || fe.o_pc !== 32'h100 || fe.o_instr !== mem_word(32'h100)) begin n_err++; $display("FAIL redir_t2 got %0b/%h/%h want 1/100/%h", fe.o_valid, fe.o_pc, fe.o_instr, mem_word(32'h100)); end
    advance();
  endtask

  task automatic test_redirect_stall();
    repeat (2) begin
      apply(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      advance();
    end
    apply(1'b1, 1'b1, 32'h203, 1'b1, 32'h777);
    n_vec++; if (fe.o_imem_req !== 1'b1 || fe.o_valid !== 1'b0) begin n_err++; $display("FAIL rs_win got %0b/%0b want 1/0", fe.o_imem_req, fe.o_valid); end
    advance();
    apply(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    n_vec++; if (fe.o_imem_addr !== 32'h200 || fe.o_valid !== 1'b0 || fe.o_instr !== IF_NOP_INSTR) begin n_err++; $display("FAIL rs_stalled got %h/%0b/%h want 200/0/nop", fe.o_imem_addr, fe.o_valid, fe.o_instr); end
    advance();
    apply(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    n_vec++; if (fe.o_imem_req !== 1'b1 || fe.o_imem_addr !== 32'h200 || fe.o_valid !== 1'b0) begin n_err++; $display("FAIL rs_fetch got %0b/%h/%0b want 1/200/0", fe.o_imem_req, fe.o_imem_addr, fe.o_valid); end
    advance();
    apply(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    n_vec++; if (fe.o_valid !== 1'b1 || fe.o_pc !== 32'h200 || fe.o_instr !== mem_word(32'h200)) begin n_err++; $display("FAIL rs_target got %0b/%h/%h want 1/200/%h", fe.o_valid, fe.o_pc, fe.o_instr, mem_word(32'h200)); end
    advance();
  endtask

  task automatic test_predict();
    logic [31:0] want_addr [6];
    logic [31:0] want_pc [6];
    logic        pt;
    want_addr = '{32'h8, 32'hC, 32'h10, 32'h40, 32'h44, 32'h48};
    want_pc   = '{32'h0, 32'h8, 32'hC, 32'h10, 32'h40, 32'h44};
    apply(1'b0, 1'b1, 32'h8, 1'b0, 32'h0);
    advance();
    for (int i = 0; i < 6; i++) begin
      pt = (m_pc == 32'h10);
      apply(1'b0, 1'b0, 32'h0, pt, 32'h43);
      n_vec++; if (fe.o_imem_addr !== want_addr[i]) begin n_err++; $display("FAIL pred_addr cyc%0d got %h want %h", i, fe.o_imem_addr, want_addr[i]); end
      if (i > 0) begin
        n_vec++; if (fe.o_valid !== 1'b1 || fe.o_pc !== want_pc[i] || fe.o_pred_taken !== (want_pc[i] == 32'h10)) begin n_err++; $display("FAIL pred_out cyc%0d got %0b/%h/%0b want 1/%h/%0b", i, fe.o_valid, fe.o_pc, fe.o_pred_taken, want_pc[i], want_pc[i] == 32'h10); end
      end
      advance();
    end
  endtask

  task automatic test_random();
    logic s, r, pt;
    for (int i = 0; i < 400; i++) begin
      s  = ($urandom_range(0, 9) < 3);
      r  = ($urandom_range(0, 9) == 0);
      pt = ($urandom_range(0, 3) == 0);
      apply(s, r, $urandom, pt, $urandom);
      n_vec++;
      if (fe.o_imem_req !== e_req || fe.o_imem_addr !== e_addr || fe.o_valid !== e_valid || fe.o_instr !== e_instr) begin
        n_err++; $display("FAIL rand_core cyc%0d got req%0b addr%h v%0b instr%h want req%0b addr%h v%0b instr%h", i, fe.o_imem_req, fe.o_imem_addr, fe.o_valid, fe.o_instr, e_req, e_addr, e_valid, e_instr);
      end
      if (e_valid) begin
        n_vec++; if (fe.o_pc !== e_pc || fe.o_pred_taken !== e_pred) begin n_err++; $display("FAIL rand_pc cyc%0d got %h/%0b want %h/%0b", i, fe.o_pc, fe.o_pred_taken, e_pc, e_pred); end
      end
`ifdef IF_PERF_CNT_EN
      n_vec++; if (fe.o_fetch_cnt !== m_fetch_cnt || fe.o_bubble_cnt !== m_bubble_cnt) begin n_err++; $display("FAIL rand_cnt cyc%0d got %h/%h want %h/%h", i, fe.o_fetch_cnt, fe.o_bubble_cnt, m_fetch_cnt, m_bubble_cnt); end
`endif
      advance();
    end
  endtask

  task automatic test_reset_mid_stall();
    repeat (2) begin
      apply(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      advance();
    end
    apply(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    advance();
    apply(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    n_vec++; if (fe.o_valid !== 1'b1) begin n_err++; $display("FAIL rstmid_pre got %0b want 1", fe.o_valid); end
    rst = 1'b1;
    #1;
    n_vec++; if (fe.o_valid !== 1'b0 || fe.o_instr !== IF_NOP_INSTR || fe.o_imem_req !== 1'b0 || fe.o_pc !== 32'h0) begin n_err++; $display("FAIL rstmid_now got %0b/%h/%0b/%h want 0/nop/0/0", fe.o_valid, fe.o_instr, fe.o_imem_req, fe.o_pc); end
    @(posedge clk);
    @(negedge clk);
`ifdef IF_PERF_CNT_EN
    n_vec++; if (fe.o_fetch_cnt !== 32'h0 || fe.o_bubble_cnt !== 32'h0) begin n_err++; $display("FAIL rstmid_cnt got %h/%h want 0/0", fe.o_fetch_cnt, fe.o_bubble_cnt); end
`endif
    rst = 1'b0;
    model_reset();
    fe.i_imem_rdata = $urandom;
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      n_vec++; if (fe.o_imem_addr !== 32'(i * 4) || fe.o_valid !== (i > 0)) begin n_err++; $display("FAIL rstmid_restart cyc%0d got %h/%0b want %h/%0b", i, fe.o_imem_addr, fe.o_valid, 32'(i * 4), i > 0); end
      if (i > 0) begin
        n_vec++; if (fe.o_instr !== mem_word(32'((i - 1) * 4))) begin n_err++; $display("FAIL rstmid_instr cyc%0d got %h want %h", i, fe.o_instr, mem_word(32'((i - 1) * 4))); end
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_predict();
    test_random();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before the scenarios finished");
    $fatal(1, "watchdog");
  end

endmodule
